// File: rtl/time_adjust_ctrl.sv
// Mode/adjust sequencer for the alarm clock field counters: turns mode/up/down
// buttons into routed one-cycle adjust strobes with hold-to-repeat and idle timeout.
module time_adjust_ctrl #(
  parameter int unsigned HOLD_DLY = 8,
  parameter int unsigned RPT_PER  = 2,
  parameter int unsigned IDLE_TO  = 40
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_tick_en,
  input  logic       i_btn_mode,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  output logic [3:0] o_adj_up,
  output logic [3:0] o_adj_down,
  output logic [3:0] o_field_sel,
  output logic       o_run_en,
  output logic       o_sec_clr
);

  localparam int unsigned CNT_MAX = (HOLD_DLY > IDLE_TO) ? HOLD_DLY : IDLE_TO;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] HOLD_HIT   = CW'(HOLD_DLY - 1);
  localparam logic [CW-1:0] IDLE_HIT   = CW'(IDLE_TO - 1);
  localparam logic [CW-1:0] CNT_SAT    = CW'(CNT_MAX);
  // Reload so the next strobe lands RPT_PER ticks after the current one
  localparam logic [CW-1:0] RPT_RELOAD = (RPT_PER >= HOLD_DLY) ? '0 : CW'(HOLD_DLY - RPT_PER);

  typedef enum logic [2:0] {
    S_RUN, S_SET_CHR, S_SET_CMIN, S_SET_AHR, S_SET_AMIN
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_mode_d, r_up_d, r_down_d;
  logic [CW-1:0]   r_rpt_cnt, w_rpt_nxt;
  logic [CW-1:0]   r_idle_cnt, w_idle_nxt;
  logic [3:0]      r_adj_up, r_adj_down, r_field_sel;
  logic            r_run_en, r_sec_clr;
  logic [3:0]      w_adj_up, w_adj_down, w_field_cur, w_field_nxt;
  logic            w_fire, w_sec_clr, w_run_en;
  logic            w_mode_edge, w_up_edge, w_down_edge;
  logic            w_up_only, w_down_only, w_any_act;

  function automatic logic [3:0] field_of(input state_t s);
    case (s)
      S_SET_CHR:  field_of = 4'b0010;
      S_SET_CMIN: field_of = 4'b0001;
      S_SET_AHR:  field_of = 4'b1000;
      S_SET_AMIN: field_of = 4'b0100;
      default:    field_of = 4'b0000;
    endcase
  endfunction

  assign w_mode_edge = i_btn_mode & ~r_mode_d;
  assign w_up_edge   = i_btn_up   & ~r_up_d;
  assign w_down_edge = i_btn_down & ~r_down_d;
  assign w_up_only   = i_btn_up   & ~i_btn_down;
  assign w_down_only = i_btn_down & ~i_btn_up;
  assign w_any_act   = i_btn_mode | i_btn_up | i_btn_down | r_mode_d | r_up_d | r_down_d;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_RUN;
      r_mode_d    <= 1'b1;
      r_up_d      <= 1'b1;
      r_down_d    <= 1'b1;
      r_rpt_cnt   <= '0;
      r_idle_cnt  <= '0;
      r_adj_up    <= '0;
      r_adj_down  <= '0;
      r_field_sel <= '0;
      r_run_en    <= 1'b1;
      r_sec_clr   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mode_d    <= i_btn_mode;
      r_up_d      <= i_btn_up;
      r_down_d    <= i_btn_down;
      r_rpt_cnt   <= w_rpt_nxt;
      r_idle_cnt  <= w_idle_nxt;
      r_adj_up    <= w_adj_up;
      r_adj_down  <= w_adj_down;
      r_field_sel <= w_field_nxt;
      r_run_en    <= w_run_en;
      r_sec_clr   <= w_sec_clr;
    end
  end

  // Next state, repeat/idle counters and adjust strobes
  always_comb begin
    w_state_nxt = r_state;
    w_rpt_nxt   = r_rpt_cnt;
    w_idle_nxt  = r_idle_cnt;
    w_fire      = 1'b0;
    w_adj_up    = '0;
    w_adj_down  = '0;
    w_field_cur = field_of(r_state);

    if (r_state == S_RUN) begin
      w_rpt_nxt  = '0;
      w_idle_nxt = '0;
      if (w_mode_edge) w_state_nxt = S_SET_CHR;
    end else if (w_mode_edge) begin
      w_rpt_nxt  = '0;
      w_idle_nxt = '0;
      case (r_state)
        S_SET_CHR:  w_state_nxt = S_SET_CMIN;
        S_SET_CMIN: w_state_nxt = S_SET_AHR;
        S_SET_AHR:  w_state_nxt = S_SET_AMIN;
        default:    w_state_nxt = S_RUN;
      endcase
    end else begin
      if (w_up_only || w_down_only) begin
        if ((w_up_only && w_up_edge) || (w_down_only && w_down_edge)) begin
          w_rpt_nxt = '0;
          w_fire    = 1'b1;
        end else if (i_tick_en) begin
          if (r_rpt_cnt == HOLD_HIT) begin
            w_rpt_nxt = RPT_RELOAD;
            w_fire    = 1'b1;
          end else if (r_rpt_cnt != CNT_SAT) begin
            w_rpt_nxt = r_rpt_cnt + 1'b1;
          end
        end
      end else begin
        w_rpt_nxt = '0;
      end

      if (w_any_act) begin
        w_idle_nxt = '0;
      end else if (i_tick_en) begin
        if (r_idle_cnt == IDLE_HIT) begin
          w_idle_nxt  = '0;
          w_state_nxt = S_RUN;
        end else if (r_idle_cnt != CNT_SAT) begin
          w_idle_nxt = r_idle_cnt + 1'b1;
        end
      end

      if (w_fire) begin
        if (w_up_only) w_adj_up   = w_field_cur;
        else           w_adj_down = w_field_cur;
      end
    end

    w_field_nxt = field_of(w_state_nxt);
    w_run_en    = !((w_state_nxt == S_SET_CHR) || (w_state_nxt == S_SET_CMIN));
    w_sec_clr   = (r_state == S_SET_CMIN) && (w_state_nxt != S_SET_CMIN);
  end

  assign o_adj_up    = r_adj_up;
  assign o_adj_down  = r_adj_down;
  assign o_field_sel = r_field_sel;
  assign o_run_en    = r_run_en;
  assign o_sec_clr   = r_sec_clr;

endmodule

// File: tb/tb_time_adjust_ctrl.sv
// Directed bench for time_adjust_ctrl with default parameters (8/2/40).
module tb_time_adjust_ctrl;

  logic       clk = 1'b0;
  logic       reset, tick_en, btn_mode, btn_up, btn_down;
  logic [3:0] adj_up, adj_down, field_sel;
  logic       run_en, sec_clr;
  int         total = 0;
  int         bad   = 0;

  time_adjust_ctrl #(.HOLD_DLY(8), .RPT_PER(2), .IDLE_TO(40)) dut (
    .i_clk(clk), .i_reset(reset), .i_tick_en(tick_en), .i_btn_mode(btn_mode),
    .i_btn_up(btn_up), .i_btn_down(btn_down), .o_adj_up(adj_up), .o_adj_down(adj_down),
    .o_field_sel(field_sel), .o_run_en(run_en), .o_sec_clr(sec_clr)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tick_step();
    tick_en = 1'b1;
    step();
    tick_en = 1'b0;
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; tick_en = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    total++;
    if (field_sel !== 4'b0000 || run_en !== 1'b1 || sec_clr !== 1'b0 ||
        adj_up !== 4'b0000 || adj_down !== 4'b0000) begin
      bad++;
      $display("FAIL reset_state: field=%b run=%b sec=%b up=%b dn=%b, required 0000 1 0 0000 0000",
               field_sel, run_en, sec_clr, adj_up, adj_down);
    end
  endtask

  task automatic test_mode_seq();
    logic [3:0] exp_f [5] = '{4'b0010, 4'b0001, 4'b1000, 4'b0100, 4'b0000};
    logic       exp_r [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int pulses = 0;
    for (int i = 0; i < 5; i++) begin
      btn_mode = 1'b1;
      step();
      total++;
      if (field_sel !== exp_f[i] || run_en !== exp_r[i]) begin
        bad++;
        $display("FAIL mode_seq[%0d]: field=%b run=%b, required %b %b",
                 i, field_sel, run_en, exp_f[i], exp_r[i]);
      end
      total++;
      if (sec_clr !== (i == 2)) begin
        bad++;
        $display("FAIL mode_seq_secclr[%0d]: sec_clr=%b, required %b", i, sec_clr, (i == 2));
      end
      if (sec_clr === 1'b1) pulses++;
      btn_mode = 1'b0;
      step();
      if (sec_clr === 1'b1) pulses++;
    end
    total++;
    if (pulses != 1) begin
      bad++;
      $display("FAIL mode_seq_secclr_count: pulses=%0d, required 1", pulses);
    end
  endtask

  task automatic test_single_adjust();
    press_mode();
    btn_up = 1'b1;
    step();
    total++;
    if (adj_up !== 4'b0010 || adj_down !== 4'b0000) begin
      bad++;
      $display("FAIL single_up: up=%b dn=%b, required 0010 0000", adj_up, adj_down);
    end
    btn_up = 1'b0;
    step();
    total++;
    if (adj_up !== 4'b0000) begin
      bad++;
      $display("FAIL single_up_width: up=%b, required 0000", adj_up);
    end
    for (int i = 0; i < 4; i++) press_mode();
    btn_up = 1'b1;
    step();
    total++;
    if (adj_up !== 4'b0000 || field_sel !== 4'b0000) begin
      bad++;
      $display("FAIL run_ignores_up: up=%b field=%b, required 0000 0000", adj_up, field_sel);
    end
    btn_up = 1'b0;
    step();
  endtask

  task automatic test_repeat();
    int pulses = 0;
    logic [3:0] exp;
    for (int i = 0; i < 4; i++) press_mode();
    btn_down = 1'b1;
    step();
    total++;
    if (adj_down !== 4'b0100 || adj_up !== 4'b0000) begin
      bad++;
      $display("FAIL repeat_first: dn=%b up=%b, required 0100 0000", adj_down, adj_up);
    end
    if (adj_down === 4'b0100) pulses++;
    for (int k = 1; k <= 14; k++) begin
      tick_step();
      exp = (k >= 8 && (k % 2) == 0) ? 4'b0100 : 4'b0000;
      total++;
      if (adj_down !== exp) begin
        bad++;
        $display("FAIL repeat_tick[%0d]: dn=%b, required %b", k, adj_down, exp);
      end
      if (adj_down === 4'b0100) pulses++;
      step();
      if (adj_down !== 4'b0000) pulses += 100;
    end
    btn_down = 1'b0;
    step();
    for (int k = 0; k < 6; k++) begin
      tick_step();
      if (adj_down !== 4'b0000) pulses++;
      step();
    end
    total++;
    if (pulses != 5) begin
      bad++;
      $display("FAIL repeat_count: pulses=%0d, required 5", pulses);
    end
    press_mode();
  endtask

  task automatic test_conflict_idle();
    int strobes = 0;
    press_mode(); press_mode();
    btn_up = 1'b1; btn_down = 1'b1;
    step();
    if (adj_up !== 4'b0000 || adj_down !== 4'b0000) strobes++;
    for (int k = 0; k < 20; k++) begin
      tick_step();
      if (adj_up !== 4'b0000 || adj_down !== 4'b0000) strobes++;
    end
    total++;
    if (strobes != 0) begin
      bad++;
      $display("FAIL conflict_strobes: strobes=%0d, required 0", strobes);
    end
    btn_up = 1'b0; btn_down = 1'b0;
    step();
    for (int k = 0; k < 39; k++) tick_step();
    total++;
    if (field_sel !== 4'b0001 || run_en !== 1'b0) begin
      bad++;
      $display("FAIL idle_before_to: field=%b run=%b, required 0001 0", field_sel, run_en);
    end
    tick_step();
    total++;
    if (field_sel !== 4'b0000 || run_en !== 1'b1 || sec_clr !== 1'b1) begin
      bad++;
      $display("FAIL idle_timeout: field=%b run=%b sec=%b, required 0000 1 1",
               field_sel, run_en, sec_clr);
    end
    step();
    total++;
    if (sec_clr !== 1'b0) begin
      bad++;
      $display("FAIL idle_secclr_width: sec_clr=%b, required 0", sec_clr);
    end
  endtask

  task automatic test_mode_vs_up_and_reset();
    int strobes = 0;
    press_mode();
    btn_mode = 1'b1; btn_up = 1'b1;
    step();
    total++;
    if (field_sel !== 4'b0001 || adj_up !== 4'b0000) begin
      bad++;
      $display("FAIL mode_beats_up: field=%b up=%b, required 0001 0000", field_sel, adj_up);
    end
    btn_mode = 1'b0; btn_up = 1'b0;
    step();
    press_mode();
    btn_up = 1'b1;
    step();
    total++;
    if (adj_up !== 4'b1000) begin
      bad++;
      $display("FAIL ahr_up: up=%b, required 1000", adj_up);
    end
    for (int k = 0; k < 3; k++) tick_step();
    reset = 1'b1;
    step();
    total++;
    if (field_sel !== 4'b0000 || run_en !== 1'b1 || sec_clr !== 1'b0 ||
        adj_up !== 4'b0000 || adj_down !== 4'b0000) begin
      bad++;
      $display("FAIL reset_mid_hold: field=%b run=%b sec=%b up=%b dn=%b, required 0000 1 0 0000 0000",
               field_sel, run_en, sec_clr, adj_up, adj_down);
    end
    reset = 1'b0;
    step();
    press_mode();
    total++;
    if (field_sel !== 4'b0010) begin
      bad++;
      $display("FAIL post_reset_mode: field=%b, required 0010", field_sel);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      if (adj_up !== 4'b0000) strobes++;
    end
    total++;
    if (strobes != 0) begin
      bad++;
      $display("FAIL held_through_reset: strobes=%0d, required 0", strobes);
    end
    btn_up = 1'b0;
    step();
    press_mode();
    reset = 1'b1;
    step();
    total++;
    if (sec_clr !== 1'b0 || field_sel !== 4'b0000 || run_en !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_cmin: sec=%b field=%b run=%b, required 0 0000 1",
               sec_clr, field_sel, run_en);
    end
    reset = 1'b0;
    step();
    total++;
    if (sec_clr !== 1'b0) begin
      bad++;
      $display("FAIL reset_in_cmin_after: sec=%b, required 0", sec_clr);
    end
  endtask

  initial begin
    test_reset();
    test_mode_seq();
    test_single_adjust();
    test_repeat();
    test_conflict_idle();
    test_mode_vs_up_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/time_adjust_ctrl.md
Name: time_adjust_ctrl

Overview:
- Mode/adjust sequencer for the alarm clock's mod-N up/down field counters: clock minutes, clock hours, alarm minutes, alarm hours.
- Converts the debounced mode/up/down buttons into one-cycle `up`/`down` strobes routed to the selected field counter.
- Provides hold-to-repeat, an idle timeout back to run mode, and the run-enable / seconds-clear controls for the timebase.

Parameters:
- HOLD_DLY, 8: tick_en strobes a button must be held before auto-repeat starts (>=1).
- RPT_PER, 2: tick_en strobes between successive auto-repeat pulses (>=1).
- IDLE_TO, 40: tick_en strobes with no button activity before a set mode returns to RUN (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tick_en  in  1  one-cycle slow timebase strobe (e.g. 4 Hz).
- btn_mode  in  1  debounced, synchronized level; rising edge advances mode.
- btn_up  in  1  debounced, synchronized level; increment request.
- btn_down  in  1  debounced, synchronized level; decrement request.
- adj_up  out  4  one-hot increment strobe; bit0 clock-min, bit1 clock-hr, bit2 alarm-min, bit3 alarm-hr.
- adj_down  out  4  one-hot decrement strobe, same bit mapping.
- field_sel  out  4  one-hot field being edited (display blink); 0 in RUN.
- run_en  out  1  timebase count enable; 0 while editing clock fields.
- sec_clr  out  1  one-cycle pulse to zero the seconds counter.

Behaviour:
- Clock/reset: clk only; reset synchronous active-high.
- Reset values:
  - state=RUN; adj_up=adj_down=0; field_sel=0; run_en=1; sec_clr=0.
  - Repeat and idle counters = 0.
  - Button history registers = 1, so a button held through reset produces no edge.
- All outputs are registered.
- FSM states: RUN, SET_CHR, SET_CMIN, SET_AHR, SET_AMIN.
  - btn_mode rising edge (sample 1, previous sample 0): RUN→SET_CHR→SET_CMIN→SET_AHR→SET_AMIN→RUN.
- field_sel per state: SET_CHR=0010, SET_CMIN=0001, SET_AHR=1000, SET_AMIN=0100, RUN=0000.
- run_en: 0 in SET_CHR and SET_CMIN; 1 in all other states.
- sec_clr: one-cycle pulse in the cycle after the FSM leaves SET_CMIN, whether by mode edge or by timeout.
- Single adjust:
  - Edge at clock edge N (btn_up sampled 1, previous sample 0, btn_down 0) → adj_up[field] = 1 for exactly the cycle after edge N.
  - btn_down is symmetric, driving adj_down.
- Auto-repeat (button held, the other button low):
  - The repeat counter increments on each tick_en, starting from the press.
  - When it reaches HOLD_DLY: one strobe, then the counter reloads so a further strobe follows every RPT_PER ticks.
  - Each strobe is one cycle, issued the cycle after the qualifying tick_en.
  - Releasing the button clears the counter.
- Conflicts:
  - btn_up and btn_down both high: no strobes; repeat counter held at 0.
  - Mode edge in the same cycle as an up/down edge: the mode transition wins, the adjust is dropped, and the repeat counter is cleared.
- RUN state: up/down ignored (no strobes). The repeat counter stays 0.
- Idle timeout (set states only):
  - The idle counter increments on tick_en.
  - It clears on any button edge or while any button is held.
  - On reaching IDLE_TO: state→RUN, field_sel=0, run_en=1, and sec_clr fires if leaving SET_CMIN.
  - In RUN the idle counter is held at 0.
- adj_up and adj_down are never both nonzero. At most one bit of each is set.
- Wrap-around and bounds are the field counters' job; this block never suppresses a strobe based on counter value.
- Counter widths are sized internally to hold max(HOLD_DLY, IDLE_TO). Counters saturate and never wrap.
- Reset mid-operation (during a set mode or a held repeat): the next cycle shows the full reset values, with no sec_clr pulse.

Test Plan:
- Reset, then three mode edges → field_sel 0010, 0001, 1000. run_en goes 0, 0, 1. sec_clr pulses once, on the SET_CMIN→SET_AHR transition.
- In SET_CHR, btn_up held for 1 clk → adj_up=0010 for exactly one cycle, the cycle after the edge. In RUN the same press → adj_up stays 0000.
- In SET_AMIN, hold btn_down with HOLD_DLY=8, RPT_PER=2 across 14 ticks → the initial strobe plus repeats at ticks 8, 10, 12, 14 (5 adj_down=0100 pulses). Release → no further pulses.
- In SET_CMIN, hold btn_up and btn_down together for 20 ticks → zero strobes. Then idle 40 ticks → state RUN, run_en=1, one sec_clr pulse.
- Mode edge coincident with an up edge in SET_CHR → state SET_CMIN, adj_up stays 0000. Assert reset while in SET_AHR holding btn_up → field_sel=0, run_en=1, no strobes, and no edge seen after reset deasserts while the button is still held.
